// File: rtl/fpu_host_if.sv
// Host-side bus interface for the FPU core: byte-lane operand staging, command
// queue, single-issue dispatcher and result queue with cmd_end/end_ack handshake.
module fpu_host_if #(
  parameter int BUS_W   = 8,
  parameter int Q_DEPTH = 4,
  parameter int OPC_W   = 4
) (
  input  logic             clk,
  input  logic             arst,
  input  logic             cs,
  input  logic             rd,
  input  logic             wr,
  input  logic [3:0]       addr,
  input  logic [BUS_W-1:0] databus_in,
  output logic [BUS_W-1:0] databus_out,
  input  logic             end_ack,
  output logic             cmd_end,
  output logic             busy,
  output logic             core_start,
  output logic [OPC_W-1:0] core_op,
  output logic [31:0]      core_a,
  output logic [31:0]      core_b,
  input  logic             core_done,
  input  logic [31:0]      core_result
);

  localparam int LANES = 32 / BUS_W;
  localparam int AW    = $clog2(Q_DEPTH);
  localparam int CNT_W = AW + 1;
  localparam int CMD_W = OPC_W + 64;

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, WBACK} state_t;

  state_t state, state_next;

  logic             wr_q, ack_q, pop_q;
  logic [31:0]      op_a, op_b;
  logic [OPC_W-1:0] op_code;
  logic             overflow, underflow, discard;
  logic [31:0]      res_latch;

  logic [CMD_W-1:0] cmd_mem [Q_DEPTH];
  logic [AW-1:0]    cmd_wp, cmd_rp;
  logic [CNT_W-1:0] cmd_cnt;
  logic [31:0]      res_mem [Q_DEPTH];
  logic [AW-1:0]    res_wp, res_rp;
  logic [CNT_W-1:0] res_cnt;

  logic wr_commit, do_push, do_flush, do_clear, ack_rise;
  logic cmd_full, cmd_empty, res_full, res_empty;
  logic cmd_wr_en, cmd_rd_en, res_wr_en, res_rd_en, issue;
  logic [31:0]      res_head;
  logic [5:0]       status;
  logic [BUS_W-1:0] rdata;

  // A write commits on the trailing (rising) edge of the sampled write strobe.
  assign wr_commit = !cs && wr && !wr_q;
  assign do_push   = wr_commit && (addr == 4'h9);
  assign do_flush  = wr_commit && (addr == 4'hE);
  assign do_clear  = wr_commit && (addr == 4'hF);
  assign ack_rise  = end_ack && !ack_q;

  assign cmd_full  = (cmd_cnt == CNT_W'(Q_DEPTH));
  assign cmd_empty = (cmd_cnt == '0);
  assign res_full  = (res_cnt == CNT_W'(Q_DEPTH));
  assign res_empty = (res_cnt == '0);

  assign cmd_wr_en = do_push && !cmd_full;
  assign res_rd_en = ack_rise && !res_empty;

  assign busy     = (state != IDLE) || !cmd_empty;
  assign res_head = res_empty ? 32'd0 : res_mem[res_rp];
  assign status   = {underflow, overflow, state != IDLE, !res_empty, cmd_empty, cmd_full};

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of block ordering.
  always_ff @(posedge clk) begin
    if (arst) begin
      wr_q      <= 1'b1;
      ack_q     <= 1'b0;
      op_a      <= '0;
      op_b      <= '0;
      op_code   <= '0;
      overflow  <= 1'b0;
      underflow <= 1'b0;
    end else begin
      wr_q  <= wr;
      ack_q <= end_ack;
      if (wr_commit) begin
        for (int k = 0; k < LANES; k++) begin
          if (addr == 4'(k))     op_a[k*BUS_W +: BUS_W] <= databus_in;
          if (addr == 4'(4 + k)) op_b[k*BUS_W +: BUS_W] <= databus_in;
        end
        if (addr == 4'h8) op_code <= databus_in[OPC_W-1:0];
      end
      if (do_push && cmd_full)        overflow  <= 1'b1;
      else if (do_clear)              overflow  <= 1'b0;
      if (ack_rise && res_empty)      underflow <= 1'b1;
      else if (do_clear)              underflow <= 1'b0;
    end
  end

  // NOTE: FIFO storage is deliberately left unreset; emptiness is tracked
  // solely by the pointers and counts, so stale contents are never observed.
  always_ff @(posedge clk) begin
    if (cmd_wr_en) cmd_mem[cmd_wp] <= {op_code, op_a, op_b};
    if (res_wr_en) res_mem[res_wp] <= res_latch;
  end

  always_ff @(posedge clk) begin
    if (arst || do_flush) begin
      cmd_wp  <= '0;
      cmd_rp  <= '0;
      cmd_cnt <= '0;
      res_wp  <= '0;
      res_rp  <= '0;
      res_cnt <= '0;
    end else begin
      if (cmd_wr_en) cmd_wp <= cmd_wp + AW'(1);
      if (cmd_rd_en) cmd_rp <= cmd_rp + AW'(1);
      cmd_cnt <= cmd_cnt + CNT_W'(cmd_wr_en) - CNT_W'(cmd_rd_en);
      if (res_wr_en) res_wp <= res_wp + AW'(1);
      if (res_rd_en) res_rp <= res_rp + AW'(1);
      res_cnt <= res_cnt + CNT_W'(res_wr_en) - CNT_W'(res_rd_en);
    end
  end

  always_ff @(posedge clk) begin
    if (arst) state <= IDLE;
    else      state <= state_next;
  end

  // NOTE: every always_comb output gets a default first so no latch is inferred.
  always_comb begin
    state_next = state;
    issue      = 1'b0;
    cmd_rd_en  = 1'b0;
    res_wr_en  = 1'b0;
    unique case (state)
      IDLE:  if (!cmd_empty && !do_flush) state_next = ISSUE;
      ISSUE: begin
        issue      = 1'b1;
        cmd_rd_en  = 1'b1;
        state_next = WAIT;
      end
      WAIT:  if (core_done) state_next = WBACK;
      WBACK: begin
        if (discard || do_flush) begin
          state_next = IDLE;
        end else if (!res_full) begin
          res_wr_en  = 1'b1;
          state_next = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (arst) begin
      core_start <= 1'b0;
      core_op    <= '0;
      core_a     <= '0;
      core_b     <= '0;
      res_latch  <= '0;
      discard    <= 1'b0;
    end else begin
      core_start <= issue;
      if (issue) {core_op, core_a, core_b} <= cmd_mem[cmd_rp];
      if (state == WAIT && core_done) res_latch <= core_result;
      // A flush with a command in flight drops that command's result.
      if (state == WBACK && state_next == IDLE) discard <= 1'b0;
      else if (do_flush && state != IDLE)       discard <= 1'b1;
    end
  end

  always_comb begin
    rdata = '0;
    if (addr == 4'h8) rdata = BUS_W'(status);
    for (int k = 0; k < LANES; k++)
      if (addr == 4'(9 + k)) rdata = res_head[k*BUS_W +: BUS_W];
  end

  // cmd_end is held low for two cycles after a pop so each result gives a new edge.
  always_ff @(posedge clk) begin
    if (arst) begin
      databus_out <= '0;
      cmd_end     <= 1'b0;
      pop_q       <= 1'b0;
    end else begin
      databus_out <= (!cs && !rd) ? rdata : '0;
      pop_q       <= res_rd_en;
      cmd_end     <= !res_empty && !res_rd_en && !pop_q;
    end
  end

endmodule

// File: tb/tb_fpu_host_if.sv
// Directed bench for fpu_host_if: an 8-bit-bus instance exercises the queues,
// flush and reset paths; a 32-bit-bus instance checks single-access lanes.
module tb_fpu_host_if;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        arst, cs8, cs32, rd, wr, ack8, ack32, core_done, core_hold;
  logic [3:0]  addr;
  logic [31:0] din, core_result;

  logic [7:0]  dout8;
  logic [31:0] dout32;
  logic        cmd_end8, cmd_end32, busy8, busy32, start8, start32;
  logic [3:0]  op8, op32;
  logic [31:0] a8, b8, a32, b32;

  fpu_host_if #(.BUS_W(8), .Q_DEPTH(4), .OPC_W(4)) dut8 (
    .clk(clk), .arst(arst), .cs(cs8), .rd(rd), .wr(wr), .addr(addr),
    .databus_in(din[7:0]), .databus_out(dout8), .end_ack(ack8),
    .cmd_end(cmd_end8), .busy(busy8), .core_start(start8), .core_op(op8),
    .core_a(a8), .core_b(b8), .core_done(core_done), .core_result(core_result)
  );

  fpu_host_if #(.BUS_W(32), .Q_DEPTH(4), .OPC_W(4)) dut32 (
    .clk(clk), .arst(arst), .cs(cs32), .rd(rd), .wr(wr), .addr(addr),
    .databus_in(din), .databus_out(dout32), .end_ack(ack32),
    .cmd_end(cmd_end32), .busy(busy32), .core_start(start32), .core_op(op32),
    .core_a(a32), .core_b(b32), .core_done(core_done), .core_result(core_result)
  );

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
  endtask

  // Core model: opcode 3 returns a fixed value, others return a^b^op.
  function automatic logic [31:0] model_fn(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
    return (op == 4'd3) ? 32'h3F35C28F : (a ^ b ^ {28'd0, op});
  endfunction

  logic [31:0] model_r;
  initial begin
    core_done   = 1'b0;
    core_result = '0;
    forever begin
      @(posedge clk); #1;
      if (start8 || start32) begin
        model_r = start8 ? model_fn(op8, a8, b8) : model_fn(op32, a32, b32);
        repeat (4) @(posedge clk);
        while (core_hold) @(posedge clk);
        #1 core_done = 1'b1; core_result = model_r;
        @(posedge clk);
        #1 core_done = 1'b0; core_result = '0;
      end
    end
  end

  int n_start8 = 0;
  int n_start32 = 0;
  always @(negedge clk) begin
    if (start8)  n_start8++;
    if (start32) n_start32++;
  end

  task automatic bus_wr(input bit wide, input logic [3:0] a, input logic [31:0] d);
    @(negedge clk);
    addr = a; din = d; wr = 1'b0;
    if (wide) cs32 = 1'b0; else cs8 = 1'b0;
    @(negedge clk);
    wr = 1'b1;
    @(negedge clk);
    cs8 = 1'b1; cs32 = 1'b1;
  endtask

  task automatic bus_rd(input bit wide, input logic [3:0] a, output logic [31:0] d);
    @(negedge clk);
    addr = a; rd = 1'b0;
    if (wide) cs32 = 1'b0; else cs8 = 1'b0;
    @(negedge clk);
    d  = wide ? dout32 : {24'd0, dout8};
    rd = 1'b1; cs8 = 1'b1; cs32 = 1'b1;
  endtask

  task automatic ack(input bit wide);
    @(negedge clk);
    if (wide) ack32 = 1'b1; else ack8 = 1'b1;
    @(negedge clk);
    ack8 = 1'b0; ack32 = 1'b0;
  endtask

  task automatic wait_end(input bit wide, input string tag);
    for (int i = 0; i < 200 && !(wide ? cmd_end32 : cmd_end8); i++) @(negedge clk);
    check({tag, "_cmd_end"}, {31'd0, wide ? cmd_end32 : cmd_end8}, 32'd1);
  endtask

  task automatic write_ab8(input logic [31:0] a, input logic [31:0] b);
    for (int k = 0; k < 4; k++) bus_wr(1'b0, 4'(k), {24'd0, a[8*k +: 8]});
    for (int k = 0; k < 4; k++) bus_wr(1'b0, 4'(4 + k), {24'd0, b[8*k +: 8]});
  endtask

  task automatic read_res8(output logic [31:0] r);
    logic [31:0] t;
    for (int k = 0; k < 4; k++) begin
      bus_rd(1'b0, 4'(9 + k), t);
      r[8*k +: 8] = t[7:0];
    end
  endtask

  localparam logic [31:0] A0 = 32'h40490FDA;
  localparam logic [31:0] B0 = 32'h402DF854;

  logic [31:0] r;
  logic [31:0] exp_q [5];
  logic [7:0]  lane_exp [4];
  int n0;

  initial begin
    arst = 1'b1; cs8 = 1'b1; cs32 = 1'b1; rd = 1'b1; wr = 1'b1;
    addr = '0; din = '0; ack8 = 1'b0; ack32 = 1'b0; core_hold = 1'b0;
    repeat (3) @(negedge clk);
    arst = 1'b0;

    // Reset state
    @(negedge clk);
    check("rst_dout",  {24'd0, dout8}, 32'd0);
    check("rst_end",   {31'd0, cmd_end8}, 32'd0);
    check("rst_busy",  {31'd0, busy8}, 32'd0);
    check("rst_start", {31'd0, start8}, 32'd0);
    check("rst_op",    {28'd0, op8}, 32'd0);
    check("rst_a",     a8, 32'd0);
    check("rst_b",     b8, 32'd0);
    bus_rd(1'b0, 4'h8, r); check("rst_status8", r, 32'h02);
    bus_rd(1'b1, 4'h8, r); check("rst_status32", r, 32'h02);

    // Single command, 8-bit bus
    write_ab8(A0, B0);
    bus_wr(1'b0, 4'h8, 32'd3);
    n0 = n_start8;
    bus_wr(1'b0, 4'h9, 32'd0);
    check("t1_busy", {31'd0, busy8}, 32'd1);
    check("t1_start_n0", {31'd0, start8}, 32'd0);
    @(negedge clk);
    check("t1_start_n1", {31'd0, start8}, 32'd0);
    @(negedge clk);
    check("t1_start_n2", {31'd0, start8}, 32'd1);
    check("t1_op", {28'd0, op8}, 32'd3);
    check("t1_a", a8, A0);
    check("t1_b", b8, B0);
    wait_end(1'b0, "t1");
    check("t1_nstart", n_start8 - n0, 32'd1);
    lane_exp = '{8'h8F, 8'hC2, 8'h35, 8'h3F};
    for (int k = 0; k < 4; k++) begin
      bus_rd(1'b0, 4'(9 + k), r);
      check($sformatf("t1_lane%0d", k), r, {24'd0, lane_exp[k]});
    end
    bus_rd(1'b0, 4'h8, r); check("t1_status", r, 32'h06);
    ack(1'b0);
    @(negedge clk);
    check("t1_end_low", {31'd0, cmd_end8}, 32'd0);
    check("t1_busy_low", {31'd0, busy8}, 32'd0);
    bus_rd(1'b0, 4'h8, r); check("t1_status_after", r, 32'h02);

    // Overflow: one command in flight with core held, four queued, sixth dropped
    core_hold = 1'b1;
    bus_wr(1'b0, 4'h8, 32'd5);
    n0 = n_start8;
    for (int i = 0; i < 6; i++) begin
      bus_wr(1'b0, 4'h0, i);
      bus_wr(1'b0, 4'h9, 32'd0);
      if (i < 5) exp_q[i] = model_fn(4'd5, {A0[31:8], 8'(i)}, B0);
    end
    bus_rd(1'b0, 4'h8, r); check("t2_status_full", r, 32'h19);
    check("t2_nstart_held", n_start8 - n0, 32'd1);
    n0 = n_start8;
    core_hold = 1'b0;
    repeat (80) @(negedge clk);
    check("t2_nstart_rel", n_start8 - n0, 32'd4);
    bus_rd(1'b0, 4'h8, r); check("t2_status_drained", r, 32'h1E);
    bus_wr(1'b0, 4'hF, 32'd0);
    bus_rd(1'b0, 4'h8, r); check("t2_status_clr", r, 32'h0E);

    // Results queued before any ack; each ack gives a fresh cmd_end edge
    for (int j = 0; j < 5; j++) begin
      wait_end(1'b0, $sformatf("t3_r%0d", j));
      read_res8(r);
      check($sformatf("t3_res%0d", j), r, exp_q[j]);
      ack(1'b0);
      @(negedge clk);
      check($sformatf("t3_low%0d", j), {31'd0, cmd_end8}, 32'd0);
    end
    repeat (3) @(negedge clk);
    check("t3_busy", {31'd0, busy8}, 32'd0);

    // Underflow on ack with empty result queue
    ack(1'b0);
    bus_rd(1'b0, 4'h8, r); check("t4_status_udf", r, 32'h22);
    bus_wr(1'b0, 4'hF, 32'd0);
    bus_rd(1'b0, 4'h8, r); check("t4_status_clr", r, 32'h02);

    // Flush during WAIT drops the in-flight result
    core_hold = 1'b1;
    n0 = n_start8;
    bus_wr(1'b0, 4'h9, 32'd0);
    repeat (4) @(negedge clk);
    bus_wr(1'b0, 4'hE, 32'd0);
    bus_rd(1'b0, 4'h8, r); check("t5_status_wait", r, 32'h0A);
    core_hold = 1'b0;
    repeat (15) @(negedge clk);
    check("t5_end", {31'd0, cmd_end8}, 32'd0);
    check("t5_busy", {31'd0, busy8}, 32'd0);
    check("t5_nstart", n_start8 - n0, 32'd1);
    bus_rd(1'b0, 4'h8, r); check("t5_status", r, 32'h02);

    // Reset in WAIT; the later core_done must be ignored
    core_hold = 1'b1;
    bus_wr(1'b0, 4'h9, 32'd0);
    repeat (4) @(negedge clk);
    check("t6_busy_wait", {31'd0, busy8}, 32'd1);
    arst = 1'b1;
    @(negedge clk);
    arst = 1'b0;
    core_hold = 1'b0;
    repeat (15) @(negedge clk);
    check("t6_end",   {31'd0, cmd_end8}, 32'd0);
    check("t6_busy",  {31'd0, busy8}, 32'd0);
    check("t6_start", {31'd0, start8}, 32'd0);
    check("t6_op",    {28'd0, op8}, 32'd0);
    check("t6_a",     a8, 32'd0);
    check("t6_b",     b8, 32'd0);
    check("t6_dout",  {24'd0, dout8}, 32'd0);
    bus_rd(1'b0, 4'h8, r); check("t6_status", r, 32'h02);

    // 32-bit bus: single-access operands and result
    bus_wr(1'b1, 4'h0, A0);
    bus_wr(1'b1, 4'h4, B0);
    bus_wr(1'b1, 4'h8, 32'd3);
    n0 = n_start32;
    bus_wr(1'b1, 4'h9, 32'd0);
    wait_end(1'b1, "t7");
    check("t7_nstart", n_start32 - n0, 32'd1);
    bus_rd(1'b1, 4'h9, r); check("t7_res", r, 32'h3F35C28F);
    bus_rd(1'b1, 4'h8, r); check("t7_status", r, 32'h06);
    ack(1'b1);
    @(negedge clk);
    check("t7_end_low", {31'd0, cmd_end32}, 32'd0);
    check("t7_busy", {31'd0, busy32}, 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
